// File: rtl/calendar_pkg.sv
// calendar_pkg: shared widths, FSM states, weekday constants and calendar helpers
package calendar_pkg;
  localparam int YEAR_W = 12;
  localparam int MONTH_W = 4;
  localparam int DAY_W = 5;
  localparam int WDAY_W = 3;
  localparam logic [WDAY_W-1:0] WDAY_SUN = 3'd0;
  localparam logic [WDAY_W-1:0] WDAY_SAT = 3'd6;
  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return (y[1:0] == 2'b00) && ((y % 12'd100 != 12'd0) || (y % 12'd400 == 12'd0));
  endfunction
  // out-of-range months fall through to 31; the set checker rejects them separately
  function automatic logic [DAY_W-1:0] month_len(input logic [YEAR_W-1:0] y, input logic [MONTH_W-1:0] m);
    return (m == 4'd2) ? (is_leap(y) ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
endpackage

// File: rtl/month_days.sv
// month_days: combinational number of days in a given year/month
module month_days
  import calendar_pkg::*;
(
  input  logic [YEAR_W-1:0]  year,
  input  logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   length
);
  assign length = month_len(year, month);
endmodule

// File: rtl/calendar_date.sv
// calendar_date: day-resolution date keeper with validated set port and carry pulses
module calendar_date
  import calendar_pkg::*;
#(
  parameter logic [YEAR_W-1:0] YEAR_MIN   = 12'd2000,
  parameter logic [YEAR_W-1:0] YEAR_MAX   = 12'd2099,
  parameter logic [WDAY_W-1:0] RESET_WDAY = 3'd6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               day_tick,
  input  logic               set_valid,
  input  logic [YEAR_W-1:0]  set_year,
  input  logic [MONTH_W-1:0] set_month,
  input  logic [DAY_W-1:0]   set_day,
  input  logic [WDAY_W-1:0]  set_wday,
  output logic               set_ready,
  output logic               set_done,
  output logic               set_err,
  output logic [YEAR_W-1:0]  year,
  output logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   day,
  output logic [WDAY_W-1:0]  wday,
  output logic               month_carry,
  output logic               year_carry
);
  state_t state, state_next;
  logic pending, pending_next, adv, legal, legal_q;
  logic [YEAR_W-1:0]  h_year;
  logic [MONTH_W-1:0] h_month;
  logic [DAY_W-1:0]   h_day, cur_len, held_len;
  logic [WDAY_W-1:0]  h_wday;
  logic end_month, end_year;

  month_days u_cur  (.year(year),   .month(month),   .length(cur_len));
  month_days u_held (.year(h_year), .month(h_month), .length(held_len));

  assign set_ready = state == IDLE;
  assign end_month = day >= cur_len;
  assign end_year  = month >= 4'd12;
  assign legal = h_year >= YEAR_MIN && h_year <= YEAR_MAX && h_month >= 4'd1 && h_month <= 4'd12 &&
                 h_day >= 5'd1 && h_day <= held_len && h_wday <= WDAY_SAT;

  // set FSM register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;

  // next state, tick application and one-deep pending tick
  always_comb begin
    state_next = state;
    adv = 1'b0;
    pending_next = pending | day_tick;
    if (state == IDLE) begin
      state_next = set_valid ? CHECK : IDLE;
      adv = pending || (day_tick && !set_valid);
      pending_next = set_valid && day_tick && !pending;
    end
    else state_next = (state == CHECK) ? COMMIT : IDLE;
  end

  // date, holding registers and registered pulses
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      year <= YEAR_MIN;
      month <= 4'd1;
      day <= 5'd1;
      wday <= RESET_WDAY;
      h_year <= YEAR_MIN;
      h_month <= 4'd1;
      h_day <= 5'd1;
      h_wday <= RESET_WDAY;
      pending <= 1'b0;
      legal_q <= 1'b0;
      set_done <= 1'b0;
      set_err <= 1'b0;
      month_carry <= 1'b0;
      year_carry <= 1'b0;
    end
    else begin
      pending <= pending_next;
      month_carry <= adv && end_month;
      year_carry <= adv && end_month && end_year;
      set_done <= state == COMMIT;
      set_err <= state == COMMIT && !legal_q;
      if (state == IDLE && set_valid) {h_year, h_month, h_day, h_wday} <= {set_year, set_month, set_day, set_wday};
      if (state == CHECK) legal_q <= legal;
      if (adv) begin
        day <= end_month ? 5'd1 : day + 5'd1;
        month <= !end_month ? month : end_year ? 4'd1 : month + 4'd1;
        year <= !(end_month && end_year) ? year : (year >= YEAR_MAX) ? YEAR_MIN : year + 12'd1;
        wday <= (wday == WDAY_SAT) ? WDAY_SUN : wday + 3'd1;
      end
      else if (state == COMMIT && legal_q) {year, month, day, wday} <= {h_year, h_month, h_day, h_wday};
    end
endmodule

// File: tb/tb_calendar_date.sv
// tb_calendar_date: directed scoreboard bench for calendar_date (default and YEAR_MAX=2100 instances)
module tb_calendar_date;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic day_tick = 1'b0, set_valid = 1'b0;
  logic [11:0] set_year = 12'd0;
  logic [3:0] set_month = 4'd0;
  logic [4:0] set_day = 5'd0;
  logic [2:0] set_wday = 3'd0;
  logic set_ready, set_done, set_err, month_carry, year_carry;
  logic [11:0] year;
  logic [3:0] month;
  logic [4:0] day;
  logic [2:0] wday;
  logic set_ready2, set_done2, set_err2, month_carry2, year_carry2;
  logic [11:0] year2;
  logic [3:0] month2;
  logic [4:0] day2;
  logic [2:0] wday2;
  int vectors = 0, errors = 0;

  typedef struct {
    logic [11:0] y;
    logic [3:0] m;
    logic [4:0] d;
    logic [2:0] w;
    logic mc, yc, done, err;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  calendar_date dut (
    .clock(clock), .reset(reset), .day_tick(day_tick), .set_valid(set_valid),
    .set_year(set_year), .set_month(set_month), .set_day(set_day), .set_wday(set_wday),
    .set_ready(set_ready), .set_done(set_done), .set_err(set_err),
    .year(year), .month(month), .day(day), .wday(wday),
    .month_carry(month_carry), .year_carry(year_carry)
  );

  calendar_date #(.YEAR_MAX(12'd2100)) dut2 (
    .clock(clock), .reset(reset), .day_tick(day_tick), .set_valid(set_valid),
    .set_year(set_year), .set_month(set_month), .set_day(set_day), .set_wday(set_wday),
    .set_ready(set_ready2), .set_done(set_done2), .set_err(set_err2),
    .year(year2), .month(month2), .day(day2), .wday(wday2),
    .month_carry(month_carry2), .year_carry(year_carry2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [11:0] y, input logic [3:0] m, input logic [4:0] d, input logic [2:0] w,
                      input logic mc, input logic yc, input logic done, input logic err);
    exp_t e;
    e.y = y; e.m = m; e.d = d; e.w = w; e.mc = mc; e.yc = yc; e.done = done; e.err = err;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag, input bit second);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".year"},  32'(second ? year2 : year), 32'(e.y));
    chk({tag, ".month"}, 32'(second ? month2 : month), 32'(e.m));
    chk({tag, ".day"},   32'(second ? day2 : day), 32'(e.d));
    chk({tag, ".wday"},  32'(second ? wday2 : wday), 32'(e.w));
    chk({tag, ".mcarry"}, 32'(second ? month_carry2 : month_carry), 32'(e.mc));
    chk({tag, ".ycarry"}, 32'(second ? year_carry2 : year_carry), 32'(e.yc));
    chk({tag, ".done"},  32'(second ? set_done2 : set_done), 32'(e.done));
    chk({tag, ".err"},   32'(second ? set_err2 : set_err), 32'(e.err));
  endtask

  task automatic set_req(input logic [11:0] y, input logic [3:0] m, input logic [4:0] d, input logic [2:0] w,
                         input bit tk);
    int n;
    @(negedge clock);
    set_valid = 1'b1;
    set_year = y; set_month = m; set_day = d; set_wday = w;
    @(negedge clock);
    set_valid = 1'b0;
    day_tick = tk;
    chk("ready_busy", 32'(set_ready), 32'd0);
    n = 0;
    while (!set_done && n < 6) begin
      @(negedge clock);
      day_tick = 1'b0;
      n++;
    end
    chk("done_seen", 32'(set_done), 32'd1);
  endtask

  task automatic tick();
    @(negedge clock);
    day_tick = 1'b1;
    @(negedge clock);
    day_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (2) @(negedge clock);
    push(12'd2000, 4'd1, 5'd1, 3'd6, 0, 0, 0, 0);
    check_out("reset", 0);
    chk("reset.ready", 32'(set_ready), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    push(12'd2000, 4'd1, 5'd1, 3'd6, 0, 0, 0, 0);
    check_out("post_reset", 0);

    push(12'd2024, 4'd2, 5'd28, 3'd3, 0, 0, 1, 0);
    set_req(12'd2024, 4'd2, 5'd28, 3'd3, 0);
    check_out("set_2024_0228", 0);
    chk("ready_idle", 32'(set_ready), 32'd1);
    push(12'd2024, 4'd2, 5'd29, 3'd4, 0, 0, 0, 0);
    tick();
    check_out("leap_0229", 0);
    push(12'd2024, 4'd3, 5'd1, 3'd5, 1, 0, 0, 0);
    tick();
    check_out("leap_0301", 0);
    push(12'd2024, 4'd3, 5'd1, 3'd5, 0, 0, 0, 0);
    @(negedge clock);
    check_out("carry_drop", 0);

    push(12'd2024, 4'd3, 5'd1, 3'd5, 0, 0, 1, 1);
    push(12'd2100, 4'd2, 5'd28, 3'd0, 0, 0, 1, 0);
    set_req(12'd2100, 4'd2, 5'd28, 3'd0, 0);
    check_out("set_2100_max2099", 0);
    check_out("set_2100_max2100", 1);
    push(12'd2024, 4'd3, 5'd2, 3'd6, 0, 0, 0, 0);
    push(12'd2100, 4'd3, 5'd1, 3'd1, 1, 0, 0, 0);
    tick();
    check_out("tick_2024_0302", 0);
    check_out("nonleap_2100_0301", 1);

    push(12'd2099, 4'd12, 5'd31, 3'd4, 0, 0, 1, 0);
    set_req(12'd2099, 4'd12, 5'd31, 3'd4, 0);
    check_out("set_2099_1231", 0);
    push(12'd2000, 4'd1, 5'd1, 3'd5, 1, 1, 0, 0);
    push(12'd2100, 4'd1, 5'd1, 3'd5, 1, 1, 0, 0);
    tick();
    check_out("year_wrap", 0);
    check_out("year_2100", 1);

    push(12'd2000, 4'd1, 5'd1, 3'd5, 0, 0, 1, 1);
    set_req(12'd2023, 4'd4, 5'd31, 3'd0, 0);
    check_out("bad_apr31", 0);
    push(12'd2000, 4'd1, 5'd1, 3'd5, 0, 0, 1, 1);
    set_req(12'd2023, 4'd13, 5'd1, 3'd0, 0);
    check_out("bad_month13", 0);
    push(12'd2000, 4'd1, 5'd1, 3'd5, 0, 0, 1, 1);
    set_req(12'd2023, 4'd1, 5'd1, 3'd7, 0);
    check_out("bad_wday7", 0);
    push(12'd2000, 4'd1, 5'd1, 3'd5, 0, 0, 1, 1);
    set_req(12'd2023, 4'd2, 5'd29, 3'd0, 0);
    check_out("bad_feb29", 0);
    push(12'd2000, 4'd1, 5'd1, 3'd5, 0, 0, 1, 1);
    set_req(12'd1999, 4'd6, 5'd1, 3'd0, 0);
    check_out("bad_1999", 0);

    push(12'd2023, 4'd6, 5'd30, 3'd5, 0, 0, 1, 0);
    set_req(12'd2023, 4'd6, 5'd30, 3'd5, 1);
    check_out("set_with_tick", 0);
    push(12'd2023, 4'd7, 5'd1, 3'd6, 1, 0, 0, 0);
    @(negedge clock);
    check_out("pending_applied", 0);

    @(negedge clock);
    set_valid = 1'b1;
    set_year = 12'd2024; set_month = 4'd5; set_day = 5'd5; set_wday = 3'd0;
    @(negedge clock);
    set_valid = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 1) reset = 1'b1;
      seen = seen | set_done;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_ready", 32'(set_ready), 32'd1);
    push(12'd2000, 4'd1, 5'd1, 3'd6, 0, 0, 0, 0);
    check_out("abort_reset_vals", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/calendar_date.md
# calendar_date

Day-resolution date keeper for the calendar datapath. Consumes the one-cycle day pulse produced at the end of the tick/counter chain and advances a registered year/month/day/weekday, handling month lengths, Gregorian leap years and year wrap. Provides a validated set port for loading a new date from the control/keypad logic. Emits month and year carry pulses for downstream display and alarm logic.

## Interface
- YEAR_MIN, 2000, lowest representable year; reset and wrap target
- YEAR_MAX, 2099, highest representable year
- RESET_WDAY, 6, weekday loaded at reset (0=Sunday … 6=Saturday; 2000-01-01 is Saturday)
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- day_tick  input  1  one-cycle pulse, advance date by one day
- set_valid  input  1  request to load set_* fields
- set_year  input  12  binary year
- set_month  input  4  1..12
- set_day  input  5  1..31
- set_wday  input  3  0..6
- set_ready  output  1  high only in IDLE; request accepted when set_valid && set_ready
- set_done  output  1  one-cycle pulse when a set request completes
- set_err  output  1  valid with set_done; 1 = request rejected, date unchanged
- year  output  12  current year
- month  output  4  current month 1..12
- day  output  5  current day 1..31
- wday  output  3  current weekday 0..6
- month_carry  output  1  one-cycle pulse on the edge where day rolls to 1
- year_carry  output  1  one-cycle pulse on the edge where month rolls to 1 (subset of month_carry)

## Operation
- Reset values: year=YEAR_MIN, month=1, day=1, wday=RESET_WDAY, set_ready=1, set_done=0, set_err=0, month_carry=0, year_carry=0, pending tick cleared, state IDLE.
- States: IDLE, CHECK, COMMIT.
- IDLE: set_valid=1 → capture set_* into holding regs, go CHECK. day_tick=1 (or pending tick) → advance date.
- CHECK: compute legality of held date: YEAR_MIN ≤ year ≤ YEAR_MAX, 1 ≤ month ≤ 12, 1 ≤ day ≤ month length, wday ≤ 6. Go COMMIT.
- COMMIT: if legal, load date regs, set_err=0; else keep date, set_err=1. Pulse set_done. Go IDLE.
- Advance: day < mlen → day+1; else day=1, month_carry; month < 12 → month+1; else month=1, year_carry; year < YEAR_MAX → year+1; else year=YEAR_MIN. wday = (wday==6) ? 0 : wday+1.
- Month length: 31/30 table; February 29 if leap else 28. Leap: divisible by 4 and (not by 100 or by 400). 2000 leap, 2100 not.
- day_tick while in CHECK/COMMIT, or coincident with accepted set_valid: latched into a one-deep pending flag; applied in the first IDLE cycle after COMMIT, to whatever date is then current (new date if set succeeded). A second tick while pending is set is lost (ticks are ≥1 s apart in practice).
- In IDLE, pending tick and new set_valid in same cycle: tick applied, set accepted same edge; held date unaffected by the tick.

## Timing
- Tick to output: date regs and carry pulses update on the edge that samples day_tick in IDLE (1 cycle).
- Set latency: accept edge → CHECK → COMMIT; date and set_done/set_err valid after the 3rd edge counted from acceptance; set_ready low for CHECK and COMMIT (2 cycles).
- Carries are registered, high exactly one cycle, aligned with the date update.
- Reset mid-set aborts: no set_done, date returns to reset values, pending dropped.

## Structure
- calendar_pkg: state enum, field widths (YEAR_W=12, MONTH_W=4, DAY_W=5, WDAY_W=3), weekday constants, is_leap and month-length functions.
- Sub-module month_days: combinational (year, month) → length 28..31, instantiated twice (current date for advance, held date for CHECK).

## Test plan
- Reset → 2000-01-01, wday=6, set_ready=1, all pulses 0.
- Set 2024-02-28 wday 3, two ticks → 2024-02-29 wday 4, then 2024-03-01 wday 5 with month_carry on second tick only.
- Set 2100-02-28 with YEAR_MAX=2100 → one tick gives 2100-03-01 (not leap).
- Set 2099-12-31 wday 4, tick → 2000-01-01 wday 5, month_carry=1 and year_carry=1 same cycle.
- Set 2023-04-31 → set_done with set_err=1, date unchanged; set month=13 and wday=7 likewise rejected.
- Set 2023-06-30 with day_tick in CHECK cycle → set_done ok, next cycle date 2023-07-01, month_carry=1; reset asserted during CHECK → no set_done, reset values.
